neur_mac_sequencer: RTL and testbench

Fast-clock operand sequencer and accumulator for the custom neural unit. It unpacks one packed 32-bit weight word and one packed 32-bit activation word at 8-, 4- or 2-bit precision into 17-bit multiplier lanes, four elements per fast cycle. It feeds the shared four-lane partial-product multiplier, then sums the returned products into a 32-bit signed accumulator. It sits directly upstream of the multiplier operand registers and returns the dot product to the neural unit.

---
 rtl/neur_mac_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_neur_mac_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neur_mac_sequencer.sv
// neur_mac_sequencer
// Unpacks one packed weight word and one packed activation word (8/4/2-bit elements) into four
// 17-bit multiplier lanes per fast cycle. It then accumulates the returned lane products into a
// 32-bit signed accumulator with a sticky overflow flag.
//
// Ports:
//   clk_i_fast  fast clock
//   rst_ni      asynchronous active-low reset
//   start_i     one-cycle request, captures weights_i / act_i / mode_i
//   mode_i      00 = 8-bit, 01 = 4-bit, 10 = 2-bit, 11 = illegal
//   weights_i   packed signed weights
//   act_i       packed unsigned activations
//   acc_clr_i   synchronous clear of accumulator and overflow flag
//   w_lane_o    sign-extended weight lanes (registered)
//   a_lane_o    zero-extended activation lanes (registered)
//   p_lane_i    lane products, PROD_LAT cycles after the lanes
//   busy_o      run in progress
//   done_o      one-cycle completion pulse
//   err_o       one-cycle pulse after a start with the illegal mode
//   acc_o       signed accumulator
//   ovf_o       sticky signed overflow
module neur_mac_sequencer #(
  parameter int unsigned PROD_LAT = 1
) (
  input  logic        clk_i_fast,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic [31:0] weights_i,
  input  logic [31:0] act_i,
  input  logic        acc_clr_i,
  output logic [16:0] w_lane_o [4],
  output logic [16:0] a_lane_o [4],
  input  logic [31:0] p_lane_i [4],
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] acc_o,
  output logic        ovf_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [31:0]         w_word_q, w_word_d;
  logic [31:0]         a_word_q, a_word_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          grp_q, grp_d;
  logic [16:0]         w_lane_q [4];
  logic [16:0]         w_lane_d [4];
  logic [16:0]         a_lane_q [4];
  logic [16:0]         a_lane_d [4];
  logic                issue_q, issue_d;
  logic [PROD_LAT-1:0] tag_q;
  logic                err_q, err_d;
  logic [31:0]         acc_q, acc_d;
  logic                ovf_q, ovf_d;

  // Element idx of word at the given precision, sign- or zero-extended to 17 bits.
  function automatic logic [16:0] unpack_elem(input logic [31:0] word, input logic [1:0] mode,
                                              input logic [3:0] idx, input logic sgn);
    logic [4:0]  off;
    logic [16:0] r;
    r = '0;
    unique case (mode)
      2'b00: begin
        off = {idx[1:0], 3'b000};
        r   = {{9{sgn & word[off+5'd7]}}, word[off +: 8]};
      end
      2'b01: begin
        off = {idx[2:0], 2'b00};
        r   = {{13{sgn & word[off+5'd3]}}, word[off +: 4]};
      end
      default: begin
        off = {idx, 1'b0};
        r   = {{15{sgn & word[off+5'd1]}}, word[off +: 2]};
      end
    endcase
    return r;
  endfunction

  function automatic logic [1:0] last_grp(input logic [1:0] mode);
    unique case (mode)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  logic        load;
  logic [31:0] src_w, src_a;
  logic [1:0]  src_mode, src_grp;
  logic        pending;
  logic        tag_out;

  // Groups still in flight other than the one whose products arrive this cycle.
  always_comb begin
    pending = issue_q;
    for (int i = 0; i < int'(PROD_LAT) - 1; i++) pending = pending | tag_q[i];
    tag_out = tag_q[PROD_LAT-1];
  end

  always_comb begin
    state_d  = state_q;
    w_word_d = w_word_q;
    a_word_d = a_word_q;
    mode_d   = mode_q;
    grp_d    = grp_q;
    err_d    = 1'b0;
    load     = 1'b0;
    // Group 0 is taken straight from the inputs so it reaches the lanes one cycle after start.
    src_w    = w_word_q;
    src_a    = a_word_q;
    src_mode = mode_q;
    src_grp  = grp_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (mode_i == 2'b11) begin
            err_d = 1'b1;
          end else begin
            w_word_d = weights_i;
            a_word_d = act_i;
            mode_d   = mode_i;
            src_w    = weights_i;
            src_a    = act_i;
            src_mode = mode_i;
            src_grp  = 2'd0;
            load     = 1'b1;
            grp_d    = 2'd1;
            state_d  = (last_grp(mode_i) == 2'd0) ? StDrain : StIssue;
          end
        end
      end
      StIssue: begin
        load  = 1'b1;
        grp_d = grp_q + 2'd1;
        if (grp_q == last_grp(mode_q)) state_d = StDrain;
      end
      StDrain: begin
        if (!pending) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase

    issue_d = load;
    for (int k = 0; k < 4; k++) begin
      w_lane_d[k] = '0;
      a_lane_d[k] = '0;
      if (load) begin
        w_lane_d[k] = unpack_elem(src_w, src_mode, {src_grp, 2'(k)}, 1'b1);
        a_lane_d[k] = unpack_elem(src_a, src_mode, {src_grp, 2'(k)}, 1'b0);
      end
    end
  end

  // Accumulate: a clear in the same cycle as a product makes the product sum the new base.
  logic [33:0] psum;
  logic [31:0] acc_base;
  logic        ovf_base;
  logic [34:0] acc_full;

  always_comb begin
    psum = '0;
    for (int k = 0; k < 4; k++) psum = psum + {{2{p_lane_i[k][31]}}, p_lane_i[k]};
    acc_base = acc_clr_i ? 32'd0 : acc_q;
    ovf_base = acc_clr_i ? 1'b0 : ovf_q;
    acc_full = {{3{acc_base[31]}}, acc_base} + {psum[33], psum};
    acc_d    = acc_base;
    ovf_d    = ovf_base;
    if (tag_out) begin
      acc_d = acc_full[31:0];
      ovf_d = ovf_base | (acc_full[34:31] != {4{acc_full[31]}});
    end
  end

  always_ff @(posedge clk_i_fast or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      w_word_q <= '0;
      a_word_q <= '0;
      mode_q   <= '0;
      grp_q    <= '0;
      issue_q  <= 1'b0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        w_lane_q[k] <= '0;
        a_lane_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      w_word_q <= w_word_d;
      a_word_q <= a_word_d;
      mode_q   <= mode_d;
      grp_q    <= grp_d;
      issue_q  <= issue_d;
      tag_q[0] <= issue_q;
      for (int i = 1; i < int'(PROD_LAT); i++) tag_q[i] <= tag_q[i-1];
      err_q    <= err_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      for (int k = 0; k < 4; k++) begin
        w_lane_q[k] <= w_lane_d[k];
        a_lane_q[k] <= a_lane_d[k];
      end
    end
  end

  assign w_lane_o = w_lane_q;
  assign a_lane_o = a_lane_q;
  assign busy_o   = (state_q == StIssue) || (state_q == StDrain);
  assign done_o   = (state_q == StDone);
  assign err_o    = err_q;
  assign acc_o    = acc_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_neur_mac_sequencer.sv
module tb_neur_mac_sequencer;
  localparam int unsigned PL = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] weights, act;
  logic        acc_clr;
  logic [16:0] w_lane [4];
  logic [16:0] a_lane [4];
  logic [31:0] p_lane [4];
  logic        busy, done, err, ovf;
  logic [31:0] acc;

  always #5 clk = ~clk;

  neur_mac_sequencer #(.PROD_LAT(PL)) dut (
    .clk_i_fast(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .weights_i(weights),
    .act_i(act), .acc_clr_i(acc_clr), .w_lane_o(w_lane), .a_lane_o(a_lane), .p_lane_i(p_lane),
    .busy_o(busy), .done_o(done), .err_o(err), .acc_o(acc), .ovf_o(ovf)
  );

  // Multiplier model: one-cycle registered product, or a fixed value for the overflow test.
  logic ovf_mode = 1'b0;

  function automatic logic [31:0] mul(input logic [16:0] w, input logic [16:0] a);
    logic signed [33:0] p;
    p = $signed(w) * $signed(a);
    return p[31:0];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) p_lane[k] <= ovf_mode ? 32'h2000_0000 : mul(w_lane[k], a_lane[k]);
  end

  int          n_chk = 0, n_fail = 0;
  logic [31:0] acc_model = '0;
  logic        ovf_model = 1'b0;
  logic [31:0] exp_q [$];

  function automatic int width_of(input logic [1:0] m);
    return (m == 2'b00) ? 8 : (m == 2'b01) ? 4 : 2;
  endfunction

  function automatic logic [16:0] lane_exp(input logic [1:0] m, input logic [31:0] word,
                                           input int idx, input bit sgn);
    int wd, v;
    wd = width_of(m);
    v  = int'((word >> (idx * wd)) & ((32'd1 << wd) - 32'd1));
    if (sgn && v >= (1 << (wd - 1))) v = v - (1 << wd);
    return 17'(v);
  endfunction

  function automatic longint dot(input logic [1:0] m, input logic [31:0] w, input logic [31:0] a);
    longint s;
    int     e;
    e = 32 / width_of(m);
    s = 0;
    if (ovf_mode) return longint'(e) * longint'(32'h2000_0000);
    for (int j = 0; j < e; j++)
      s += longint'($signed(lane_exp(m, w, j, 1))) * longint'(lane_exp(m, a, j, 0));
    return s;
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [31:0] w, input logic [31:0] a,
                        input bit inject);
    int          n_grp, lat_exp, cyc, extra;
    longint      t;
    bit          seen;
    logic [31:0] e_acc;
    n_grp   = 32 / width_of(m) / 4;
    lat_exp = n_grp + int'(PL) + 1;
    t = longint'($signed(acc_model)) + dot(m, w, a);
    if (t > 64'sd2147483647 || t < -64'sd2147483648) ovf_model = 1'b1;
    acc_model = t[31:0];
    exp_q.push_back(acc_model);
    @(posedge clk); #1;
    start = 1'b1; mode = m; weights = w; act = a;
    @(posedge clk); #1;
    start = 1'b0;
    cyc  = 1;
    seen = 0;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_cycle1: got %b want 1", busy);
    end
    while (cyc <= 20 && !seen) begin
      for (int k = 0; k < 4; k++) begin
        logic [16:0] ew, ea;
        ew = (cyc <= n_grp) ? lane_exp(m, w, 4 * (cyc - 1) + k, 1) : 17'd0;
        ea = (cyc <= n_grp) ? lane_exp(m, a, 4 * (cyc - 1) + k, 0) : 17'd0;
        n_chk++;
        if (w_lane[k] !== ew || a_lane[k] !== ea) begin
          n_fail++;
          $display("FAIL lanes cyc%0d k%0d: got w=%h a=%h want w=%h a=%h", cyc, k, w_lane[k],
                   a_lane[k], ew, ea);
        end
      end
      if (inject && cyc == 2) begin
        start = 1'b1; mode = 2'b00; weights = '1; act = '1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        seen = 1;
        n_chk++;
        if (cyc != lat_exp) begin
          n_fail++; $display("FAIL latency: got %0d want %0d", cyc, lat_exp);
        end
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL scoreboard: got done with empty queue want entry");
        end else begin
          e_acc = exp_q.pop_front();
          if (acc !== e_acc) begin
            n_fail++; $display("FAIL acc_at_done: got %h want %h", acc, e_acc);
          end
        end
        n_chk++;
        if (ovf !== ovf_model) begin
          n_fail++; $display("FAIL ovf_at_done: got %b want %b", ovf, ovf_model);
        end
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done want done in cycle %0d", lat_exp);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (inject) begin
      extra = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (done === 1'b1 || err === 1'b1) extra++;
      end
      n_chk++;
      if (extra != 0) begin
        n_fail++; $display("FAIL ignored_start: got %0d extra pulses want 0", extra);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [31:0] e_acc, input logic e_ovf);
    bit bad;
    bad = (busy !== 1'b0) || (done !== 1'b0) || (err !== 1'b0) || (acc !== e_acc) ||
          (ovf !== e_ovf);
    for (int k = 0; k < 4; k++) bad |= (w_lane[k] !== 17'd0) || (a_lane[k] !== 17'd0);
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b err=%b acc=%h ovf=%b w0=%h a0=%h want acc=%h ovf=%b",
               name, busy, done, err, acc, ovf, w_lane[0], a_lane[0], e_acc, e_ovf);
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1; acc_clr = 1'b1;
    @(posedge clk); #1; acc_clr = 1'b0;
    acc_model = '0; ovf_model = 1'b0;
    n_chk++;
    if (acc !== 32'd0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL acc_clear: got acc=%h ovf=%b want 0 0", acc, ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = '0; weights = '0; act = '0; acc_clr = 1'b0;
    #1;
    check_idle_outputs("reset_state", 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_8bit();
    run_op(2'b00, 32'h01FF_02FE, 32'h0403_0201, 0);
    n_chk++;
    if (acc !== 32'd3) begin
      n_fail++; $display("FAIL acc_8bit: got %0d want 3", $signed(acc));
    end
  endtask

  task automatic test_4bit();
    do_clear();
    run_op(2'b01, 32'h1111_1111, 32'hFFFF_FFFF, 0);
    n_chk++;
    if (acc !== 32'd120) begin
      n_fail++; $display("FAIL acc_4bit: got %0d want 120", $signed(acc));
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    run_op(2'b10, 32'hFFFF_FFFF, 32'h5555_5555, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h5555_5555, 0);
    n_chk++;
    if (acc !== -32'sd32) begin
      n_fail++; $display("FAIL acc_2bit_twice: got %0d want -32", $signed(acc));
    end
    do_clear();
  endtask

  task automatic test_protocol();
    run_op(2'b00, 32'h0102_0304, 32'h0A0B_0C0D, 0);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b11; weights = '1; act = '1;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++;
    if (err !== 1'b1 || busy !== 1'b0 || acc !== acc_model) begin
      n_fail++; $display("FAIL err_pulse: got err=%b busy=%b acc=%h want 1 0 %h", err, busy, acc,
                         acc_model);
    end
    @(posedge clk); #1;
    check_idle_outputs("err_after", acc_model, ovf_model);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h5555_5555, 1);
  endtask

  task automatic test_overflow();
    do_clear();
    ovf_mode = 1'b1;
    run_op(2'b00, 32'h0101_0101, 32'h0101_0101, 0);
    n_chk++;
    if (acc !== 32'h8000_0000 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_first: got acc=%h ovf=%b want 80000000 1", acc, ovf);
    end
    run_op(2'b00, 32'h0101_0101, 32'h0101_0101, 0);
    n_chk++;
    if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf);
    end
    ovf_mode = 1'b0;
    do_clear();
  endtask

  task automatic test_reset_mid();
    int stale;
    run_op(2'b00, 32'h01FF_02FE, 32'h0403_0201, 0);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b10; weights = 32'hFFFF_FFFF; act = 32'h5555_5555;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_run", 32'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_model = '0; ovf_model = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1 || acc !== 32'd0) stale++;
    end
    n_chk++;
    if (stale != 0) begin
      n_fail++; $display("FAIL stale_after_reset: got %0d bad cycles want 0", stale);
    end
    run_op(2'b00, 32'h01FF_02FE, 32'h0403_0201, 0);
    n_chk++;
    if (acc !== 32'd3) begin
      n_fail++; $display("FAIL acc_after_reset: got %0d want 3", $signed(acc));
    end
  endtask

  initial begin
    test_reset();
    test_8bit();
    test_4bit();
    test_back_to_back();
    test_protocol();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
